// File: rtl/sme_seq_pkg.sv
// rtl/sme_seq_pkg.sv - shared types and constants for the match-job sequencer
// Sequencer states plus buffer capacities and engine character codes.
package sme_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_GAP,
    ST_WAIT
  } seq_state_e;

  localparam int SME_STR_MAX = 32;
  localparam int SME_PAT_MAX = 8;

  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_NUL   = 8'h00;

endpackage

// File: rtl/sme_job_sequencer_if.sv
// rtl/sme_job_sequencer_if.sv - host load, engine and result bundle of the sequencer
// slave is the sequencer side; master is the host/engine side.
interface sme_job_sequencer_if #(
  parameter int PID_W = 2
);
  logic             ld_valid;
  logic             ld_ready;
  logic             ld_sel;
  logic [PID_W-1:0] ld_pid;
  logic [7:0]       ld_data;
  logic             ld_last;
  logic             start;
  logic [PID_W:0]   npat;
  logic             busy;
  logic [7:0]       eng_chardata;
  logic             eng_isstring;
  logic             eng_ispattern;
  logic             eng_valid;
  logic             eng_match;
  logic [4:0]       eng_match_index;
  logic             res_valid;
  logic [PID_W-1:0] res_pid;
  logic             res_match;
  logic [4:0]       res_index;
  logic             done;
  logic             err;

  modport slave (
    input  ld_valid, ld_sel, ld_pid, ld_data, ld_last, start, npat,
           eng_valid, eng_match, eng_match_index,
    output ld_ready, busy, eng_chardata, eng_isstring, eng_ispattern,
           res_valid, res_pid, res_match, res_index, done, err
  );

  modport master (
    output ld_valid, ld_sel, ld_pid, ld_data, ld_last, start, npat,
           eng_valid, eng_match, eng_match_index,
    input  ld_ready, busy, eng_chardata, eng_isstring, eng_ispattern,
           res_valid, res_pid, res_match, res_index, done, err
  );
endinterface

// File: rtl/sme_job_buf.sv
// rtl/sme_job_buf.sv - string and pattern storage for one match job
// Saturating write pointers per item; combinational read port indexed by (sel, pid, idx).
module sme_job_buf
  import sme_seq_pkg::*;
#(
  parameter int NPAT  = 4,
  parameter int PID_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [PID_W-1:0] wr_pid,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  input  logic             rd_sel,
  input  logic [PID_W-1:0] rd_pid,
  input  logic [4:0]       rd_idx,
  output logic [7:0]       rd_data,
  output logic [5:0]       str_len,
  output logic [3:0]       pat_len
);
  localparam logic [5:0] STR_CAP = 6'(SME_STR_MAX);
  localparam logic [3:0] PAT_CAP = 4'(SME_PAT_MAX);

  logic [7:0] str_mem_q [SME_STR_MAX];
  logic [7:0] pat_mem_q [NPAT][SME_PAT_MAX];
  logic [5:0] str_wptr_q, str_wptr_d, str_len_q, str_len_d;
  logic [3:0] pat_wptr_q [NPAT];
  logic [3:0] pat_wptr_d [NPAT];
  logic [3:0] pat_len_q [NPAT];
  logic [3:0] pat_len_d [NPAT];

  always_comb begin
    str_wptr_d = str_wptr_q;
    str_len_d  = str_len_q;
    pat_wptr_d = pat_wptr_q;
    pat_len_d  = pat_len_q;
    // A saturated pointer means the closing character was dropped, so the length stays at capacity.
    if (wr_en && !wr_sel) begin
      if (wr_last) begin
        str_len_d  = (str_wptr_q == STR_CAP) ? STR_CAP : str_wptr_q + 6'd1;
        str_wptr_d = '0;
      end else if (str_wptr_q != STR_CAP) begin
        str_wptr_d = str_wptr_q + 6'd1;
      end
    end
    if (wr_en && wr_sel) begin
      if (wr_last) begin
        pat_len_d[wr_pid]  = (pat_wptr_q[wr_pid] == PAT_CAP) ? PAT_CAP : pat_wptr_q[wr_pid] + 4'd1;
        pat_wptr_d[wr_pid] = '0;
      end else if (pat_wptr_q[wr_pid] != PAT_CAP) begin
        pat_wptr_d[wr_pid] = pat_wptr_q[wr_pid] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_wptr_q <= '0;
      str_len_q  <= '0;
      for (int i = 0; i < NPAT; i++) begin
        pat_wptr_q[i] <= '0;
        pat_len_q[i]  <= '0;
      end
    end else begin
      str_wptr_q <= str_wptr_d;
      str_len_q  <= str_len_d;
      pat_wptr_q <= pat_wptr_d;
      pat_len_q  <= pat_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel && str_wptr_q < STR_CAP)
      str_mem_q[str_wptr_q[4:0]] <= wr_data;
    if (wr_en && wr_sel && pat_wptr_q[wr_pid] < PAT_CAP)
      pat_mem_q[wr_pid][pat_wptr_q[wr_pid][2:0]] <= wr_data;
  end

  assign rd_data = rd_sel ? pat_mem_q[rd_pid][rd_idx[2:0]] : str_mem_q[rd_idx];
  assign str_len = str_len_q;
  assign pat_len = pat_len_q[rd_pid];

endmodule

// File: rtl/sme_job_sequencer.sv
// rtl/sme_job_sequencer.sv - feeds a buffered match job to the string-match engine
// Serialises string then patterns, aligns to engine valid cycles and returns per-pattern results.
module sme_job_sequencer
  import sme_seq_pkg::*;
#(
  parameter int NPAT    = 4,
  parameter int PID_W   = 2,
  parameter int TIMEOUT = 4095,
  parameter int TO_W    = 12
) (
  input logic                 clk,
  input logic                 reset,
  sme_job_sequencer_if.slave  bus
);
  localparam logic [PID_W-1:0] K_ONE  = 1;
  localparam logic [PID_W:0]   N_ONE  = 1;
  localparam logic [TO_W-1:0]  TO_ONE = 1;
  localparam logic [TO_W-1:0]  TO_HIT = TO_W'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic             primed_q, primed_d;
  logic [4:0]       idx_q, idx_d;
  logic [PID_W-1:0] k_q, k_d;
  logic [PID_W:0]   npat_q, npat_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [PID_W-1:0] res_pid_q, res_pid_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             rd_sel;
  logic [PID_W-1:0] rd_pid;
  logic [4:0]       rd_idx;
  logic [7:0]       rd_data;
  logic [5:0]       str_len;
  logic [3:0]       pat_len;
  logic             last_pat;
  logic             to_hit;
  logic             wr_en;

  assign wr_en = bus.ld_valid && (state_q == ST_IDLE);

  sme_job_buf #(.NPAT(NPAT), .PID_W(PID_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (bus.ld_sel),
    .wr_pid  (bus.ld_pid),
    .wr_data (bus.ld_data),
    .wr_last (bus.ld_last),
    .rd_sel  (rd_sel),
    .rd_pid  (rd_pid),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .str_len (str_len),
    .pat_len (pat_len)
  );

  always_comb begin
    state_d     = state_q;
    primed_d    = primed_q;
    idx_d       = idx_q;
    k_d         = k_q;
    npat_d      = npat_q;
    to_cnt_d    = to_cnt_q;
    res_valid_d = 1'b0;
    res_pid_d   = res_pid_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    done_d      = 1'b0;
    err_d       = err_q;
    bus.eng_chardata  = CH_NUL;
    bus.eng_isstring  = 1'b0;
    bus.eng_ispattern = 1'b0;
    rd_sel   = 1'b0;
    rd_pid   = k_q;
    rd_idx   = idx_q;
    last_pat = ({1'b0, k_q} + N_ONE) >= npat_q;
    to_hit   = (to_cnt_q == TO_HIT);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.npat == '0) begin
            done_d = 1'b1;
          end else begin
            npat_d   = bus.npat;
            k_d      = '0;
            idx_d    = '0;
            to_cnt_d = '0;
            primed_d = 1'b1;
            // An engine that has already run a job is free-running, so the string must wait for a valid slot.
            state_d  = primed_q ? ST_ARM : ST_SEND_STR;
          end
        end
      end
      ST_ARM: begin
        rd_idx           = '0;
        bus.eng_isstring = 1'b1;
        bus.eng_chardata = rd_data;
        if (bus.eng_valid) begin
          if (str_len <= 6'd1) begin
            state_d = ST_SEND_PAT;
            idx_d   = '0;
          end else begin
            state_d = ST_SEND_STR;
            idx_d   = 5'd1;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      ST_SEND_STR: begin
        bus.eng_isstring = 1'b1;
        bus.eng_chardata = rd_data;
        if (({1'b0, idx_q} + 6'd1) >= str_len) begin
          state_d = ST_SEND_PAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_SEND_PAT: begin
        rd_sel            = 1'b1;
        bus.eng_ispattern = 1'b1;
        bus.eng_chardata  = rd_data;
        if (({1'b0, idx_q} + 6'd1) >= {2'b00, pat_len}) begin
          state_d = ST_GAP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_GAP: begin
        state_d  = ST_WAIT;
        to_cnt_d = '0;
      end
      ST_WAIT: begin
        rd_sel = 1'b1;
        rd_pid = k_q + K_ONE;
        rd_idx = '0;
        // Pre-drive the next pattern head so the engine consumes it in the valid cycle.
        if (!last_pat) begin
          bus.eng_ispattern = 1'b1;
          bus.eng_chardata  = rd_data;
        end
        if (bus.eng_valid) begin
          res_valid_d = 1'b1;
          res_pid_d   = k_q;
          res_match_d = bus.eng_match;
          res_index_d = bus.eng_match_index;
          if (last_pat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + K_ONE;
            if (pat_len <= 4'd1) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_SEND_PAT;
              idx_d   = 5'd1;
            end
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      primed_q    <= 1'b0;
      idx_q       <= '0;
      k_q         <= '0;
      npat_q      <= '0;
      to_cnt_q    <= '0;
      res_valid_q <= 1'b0;
      res_pid_q   <= '0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      npat_q      <= npat_d;
      to_cnt_q    <= to_cnt_d;
      res_valid_q <= res_valid_d;
      res_pid_q   <= res_pid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.ld_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_pid   = res_pid_q;
  assign bus.res_match = res_match_q;
  assign bus.res_index = res_index_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
